// File: rtl/clkdiv_pkg.sv
// clkdiv_pkg: shared widths, reset divisor and state encodings for the clock-enable scheduler
package clkdiv_pkg;
   localparam int DIVW    = 27;
   localparam int DEF_DIV = 50000000;
   localparam int MIN_DIV = 2;
   typedef enum logic {CH_IDLE = 1'b0, CH_RUN = 1'b1} ch_state_t;
   typedef enum logic {SLOT_EMPTY = 1'b0, SLOT_HOLD = 1'b1} slot_state_t;
endpackage

// File: rtl/clk_en_chan.sv
// clk_en_chan: one programmable divider channel producing a period tick and a square enable
module clk_en_chan #(
   parameter int DIVW    = clkdiv_pkg::DIVW,
   parameter int DEF_DIV = clkdiv_pkg::DEF_DIV
) (
   input  logic            clki,
   input  logic            rst,
   input  logic            apply_start,
   input  logic            apply_stop,
   input  logic            apply_div,
   input  logic [DIVW-1:0] new_div,
   output logic            wrap,
   output logic            tick,
   output logic            sq,
   output logic            busy
);
   import clkdiv_pkg::*;
   ch_state_t       state, state_n;
   logic [DIVW-1:0] cnt, cnt_n, div, div_n;
   logic            tick_n, sq_n;
   assign busy = (state == CH_RUN);
   assign wrap = busy && (cnt == div - 1'b1);
   always_ff @(posedge clki or posedge rst)
      if (rst) begin
         state <= CH_IDLE;
         cnt   <= '0;
         div   <= DIVW'(DEF_DIV);
         tick  <= 1'b0;
         sq    <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         div   <= div_n;
         tick  <= tick_n;
         sq    <= sq_n;
      end
   // sq is derived from the next count so it stays aligned with the registered cnt
   always_comb begin
      state_n = apply_start ? CH_RUN : apply_stop ? CH_IDLE : state;
      div_n   = (apply_start || apply_div) ? new_div : div;
      cnt_n   = (state_n == CH_RUN && !apply_start && !wrap) ? cnt + 1'b1 : '0;
      tick_n  = wrap && !apply_stop;
      sq_n    = (state_n == CH_RUN) && (cnt_n >= (div_n >> 1));
   end
endmodule

// File: rtl/clk_en_sched.sv
// clk_en_sched: NCH independent clock-enable dividers sharing one pending config slot
module clk_en_sched #(
   parameter int NCH     = 4,
   parameter int DIVW    = clkdiv_pkg::DIVW,
   parameter int DEF_DIV = clkdiv_pkg::DEF_DIV,
   parameter int MIN_DIV = clkdiv_pkg::MIN_DIV
) (
   input  logic            clki,
   input  logic            rst,
   input  logic            cfg_valid,
   output logic            cfg_ready,
   input  logic [2:0]      cfg_ch,
   input  logic [DIVW-1:0] cfg_div,
   input  logic            cfg_en,
   output logic [NCH-1:0]  tick,
   output logic [NCH-1:0]  sq,
   output logic [NCH-1:0]  busy
);
   import clkdiv_pkg::*;
   slot_state_t     slot, slot_n;
   logic [2:0]      p_ch;
   logic [DIVW-1:0] p_div;
   logic            p_en;
   logic [NCH-1:0]  sel, wrap, a_start, a_stop, a_div;
   logic            accept, done;
   assign cfg_ready = (slot == SLOT_EMPTY);
   assign accept    = cfg_valid && cfg_ready;
   // only a retune of a running channel waits; everything else retires on the next edge
   assign done      = (slot == SLOT_HOLD) && (~|sel || !p_en || ~|(sel & busy) || |(sel & wrap));
   always_comb slot_n = accept ? SLOT_HOLD : done ? SLOT_EMPTY : slot;
   always_ff @(posedge clki or posedge rst)
      if (rst) begin
         slot  <= SLOT_EMPTY;
         p_ch  <= '0;
         p_div <= '0;
         p_en  <= 1'b0;
      end else begin
         slot <= slot_n;
         if (accept) begin
            p_ch  <= cfg_ch;
            p_div <= (cfg_div < DIVW'(MIN_DIV)) ? DIVW'(MIN_DIV) : cfg_div;
            p_en  <= cfg_en;
         end
      end
   for (genvar i = 0; i < NCH; i++) begin : g_ch
      assign sel[i]     = (slot == SLOT_HOLD) && (p_ch == 3'(i));
      assign a_start[i] = sel[i] && !busy[i] && p_en;
      assign a_stop[i]  = sel[i] && busy[i] && !p_en;
      assign a_div[i]   = sel[i] && (busy[i] ? (p_en && wrap[i]) : !p_en);
      clk_en_chan #(.DIVW(DIVW), .DEF_DIV(DEF_DIV)) u_chan (
         .clki        (clki),
         .rst         (rst),
         .apply_start (a_start[i]),
         .apply_stop  (a_stop[i]),
         .apply_div   (a_div[i]),
         .new_div     (p_div),
         .wrap        (wrap[i]),
         .tick        (tick[i]),
         .sq          (sq[i]),
         .busy        (busy[i])
      );
   end
endmodule

// File: tb/tb_clk_en_sched.sv
// tb_clk_en_sched: table-driven and scripted checks of the clock-enable scheduler
module tb_clk_en_sched;
   logic        clki = 1'b0;
   logic        rst = 1'b1;
   logic        cfg_valid = 1'b0;
   logic        cfg_ready;
   logic [2:0]  cfg_ch = '0;
   logic [26:0] cfg_div = '0;
   logic        cfg_en = 1'b0;
   logic [3:0]  tick, sq, busy;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          n;
   typedef struct {
      logic v; logic [2:0] ch; logic [26:0] dv; logic en;
      logic [3:0] tk; logic [3:0] sq; logic [3:0] bz; logic rdy;
   } vec_t;
   vec_t tbl[29];
   clk_en_sched dut (
      .clki(clki), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en),
      .tick(tick), .sq(sq), .busy(busy)
   );
   always #5 clki = ~clki;
   function automatic vec_t mk(logic v, int ch, int dv, logic en,
                               logic [3:0] tk, logic [3:0] s, logic [3:0] bz, logic rdy);
      mk = '{v, 3'(ch), 27'(dv), en, tk, s, bz, rdy};
   endfunction
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask
   task automatic step;
      @(posedge clki);
      #1;
   endtask
   task automatic drive(input logic v, input int ch, input int dv, input logic en);
      cfg_valid = v;
      cfg_ch    = 3'(ch);
      cfg_div   = 27'(dv);
      cfg_en    = en;
   endtask
   task automatic wait_tick(input int c, input int lim, output int cnt);
      cnt = -1;
      for (int k = 1; k <= lim; k++) begin
         step;
         if (tick[c]) begin
            cnt = k;
            break;
         end
      end
   endtask
   initial begin
      // row k: inputs before edge k, expected outputs after edge k
      tbl[0]  = mk(1, 0, 4, 1, 4'b0000, 4'b0000, 4'b0000, 0);
      tbl[1]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
      tbl[2]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
      tbl[3]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 1);
      tbl[4]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 1);
      tbl[5]  = mk(0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0001, 1);
      tbl[6]  = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
      tbl[7]  = mk(1, 0, 6, 1, 4'b0000, 4'b0001, 4'b0001, 0);
      tbl[8]  = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 0);
      tbl[9]  = mk(0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0001, 1);
      tbl[10] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
      tbl[11] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0001, 1);
      tbl[12] = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 1);
      tbl[13] = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 1);
      tbl[14] = mk(0, 0, 0, 0, 4'b0000, 4'b0001, 4'b0001, 1);
      tbl[15] = mk(0, 0, 0, 0, 4'b0001, 4'b0000, 4'b0001, 1);
      tbl[16] = mk(1, 1, 0, 1, 4'b0000, 4'b0000, 4'b0001, 0);
      tbl[17] = mk(0, 0, 0, 0, 4'b0000, 4'b0000, 4'b0011, 1);
      tbl[18] = mk(1, 1, 1, 1, 4'b0000, 4'b0011, 4'b0011, 0);
      tbl[19] = mk(0, 0, 0, 0, 4'b0010, 4'b0001, 4'b0011, 1);
      tbl[20] = mk(0, 0, 0, 0, 4'b0000, 4'b0011, 4'b0011, 1);
      tbl[21] = mk(0, 0, 0, 0, 4'b0011, 4'b0000, 4'b0011, 1);
      tbl[22] = mk(0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0011, 1);
      tbl[23] = mk(0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0011, 1);
      tbl[24] = mk(1, 0, 4, 0, 4'b0000, 4'b0011, 4'b0011, 0);
      tbl[25] = mk(0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0010, 1);
      tbl[26] = mk(0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0010, 1);
      tbl[27] = mk(0, 0, 0, 0, 4'b0010, 4'b0000, 4'b0010, 1);
      tbl[28] = mk(0, 0, 0, 0, 4'b0000, 4'b0010, 4'b0010, 1);
      step;
      chk("reset_tick", tick, 0);
      chk("reset_sq", sq, 0);
      chk("reset_busy", busy, 0);
      chk("reset_ready", cfg_ready, 1);
      rst = 1'b0;
      for (int k = 0; k < 29; k++) begin
         drive(tbl[k].v, tbl[k].ch, tbl[k].dv, tbl[k].en);
         step;
         chk($sformatf("tbl%0d_tick", k), tick, tbl[k].tk);
         chk($sformatf("tbl%0d_sq", k), sq, tbl[k].sq);
         chk($sformatf("tbl%0d_busy", k), busy, tbl[k].bz);
         chk($sformatf("tbl%0d_ready", k), cfg_ready, tbl[k].rdy);
      end
      // back-pressure: second write to running ch2 waits for its wrap
      drive(1, 2, 8, 1); step;
      drive(0, 0, 0, 0); step;
      chk("ch2_start_busy", busy[2], 1);
      drive(1, 2, 8, 1); step;
      chk("bp_accept_a", cfg_ready, 0);
      drive(1, 2, 4, 1);
      for (int k = 0; k < 6; k++) begin
         step;
         chk($sformatf("bp_hold_b%0d", k), cfg_ready, 0);
      end
      step;
      chk("bp_wrap_ready", cfg_ready, 1);
      chk("bp_wrap_tick", tick[2], 1);
      step;
      chk("bp_accept_b", cfg_ready, 0);
      drive(0, 0, 0, 0);
      wait_tick(2, 20, n);
      chk("bp_old_period", n, 7);
      chk("bp_b_applied_ready", cfg_ready, 1);
      wait_tick(2, 20, n);
      chk("bp_new_period", n, 4);
      // asynchronous reset with a write still pending
      drive(1, 2, 8, 1); step;
      chk("rst_pending", cfg_ready, 0);
      drive(0, 0, 0, 0); step;
      #3 rst = 1'b1;
      #1;
      chk("arst_tick", tick, 0);
      chk("arst_sq", sq, 0);
      chk("arst_busy", busy, 0);
      chk("arst_ready", cfg_ready, 1);
      @(posedge clki);
      #1 rst = 1'b0;
      for (int k = 0; k < 12; k++) begin
         step;
         chk($sformatf("post_rst_idle%0d", k), {busy, tick, 3'b000, cfg_ready}, 9'h001);
      end
      drive(1, 5, 3, 1); step;
      chk("inv_ch_accept", cfg_ready, 0);
      drive(0, 0, 0, 0); step;
      chk("inv_ch_ready", cfg_ready, 1);
      chk("inv_ch_busy", busy, 0);
      drive(1, 3, 3, 1); step;
      drive(0, 0, 0, 0); step;
      chk("ch3_start_busy", busy, 4'b1000);
      wait_tick(3, 10, n);
      chk("ch3_period", n, 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
